// File: rtl/count_ctrl_if.sv
// Command handshake between the bus register file (master) and count_ctrl (slave).
interface count_ctrl_if #(
   parameter int COUNT_WIDTH = 32
);
   logic                   cmd_valid;
   logic [1:0]             cmd;
   logic [COUNT_WIDTH-1:0] cmd_data;
   logic                   cmd_ready;
   logic                   cmd_done;

   modport master (
      output cmd_valid,
      output cmd,
      output cmd_data,
      input  cmd_ready,
      input  cmd_done
   );

   modport slave (
      input  cmd_valid,
      input  cmd,
      input  cmd_data,
      output cmd_ready,
      output cmd_done
   );
endinterface

// File: rtl/count_ctrl.sv
// Signed position register for one slow-pulse count channel, with host commands
// (CLEAR / PRESET / SNAPSHOT) executed by a three-state Moore controller.
//
// state  | meaning
// S_IDLE | ready for a command; latches cmd/cmd_data on cmd_valid
// S_EXEC | applies the latched command; a pulse colliding with a load is parked
// S_ACK  | cmd_done high; parked pulse is applied to the loaded value
module count_ctrl #(
   parameter int COUNT_WIDTH = 32,
   parameter bit SATURATE    = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   inc_counter,
   input  logic                   dec_counter,
   input  logic                   enable,
   count_ctrl_if.slave            cmd_bus,
   output logic [COUNT_WIDTH-1:0] count_value,
   output logic [COUNT_WIDTH-1:0] snapshot,
   output logic                   snapshot_valid,
   output logic                   overflow,
   output logic                   underflow
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   localparam logic [1:0] CMD_CLEAR    = 2'b01;
   localparam logic [1:0] CMD_PRESET   = 2'b10;
   localparam logic [1:0] CMD_SNAPSHOT = 2'b11;

   localparam logic [COUNT_WIDTH-1:0] MAX_VAL = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
   localparam logic [COUNT_WIDTH-1:0] MIN_VAL = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
   localparam logic [COUNT_WIDTH-1:0] ONE     = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]             state;
   logic [1:0]             cmd_q;
   logic [COUNT_WIDTH-1:0] data_q;
   logic                   pend_inc;
   logic                   pend_dec;

   logic                   pulse_inc;
   logic                   pulse_dec;
   logic                   step_inc;
   logic                   step_dec;
   logic                   do_load;
   logic                   do_clear;
   logic                   do_snap;
   logic                   ovf_hit;
   logic                   unf_hit;
   logic [COUNT_WIDTH-1:0] next_count;

   assign cmd_bus.cmd_ready = (state == S_IDLE);
   assign cmd_bus.cmd_done  = (state == S_ACK);

   always_comb begin
      pulse_inc  = inc_counter & enable;
      pulse_dec  = dec_counter & enable;
      do_clear   = (state == S_EXEC) && (cmd_q == CMD_CLEAR);
      do_load    = do_clear || ((state == S_EXEC) && (cmd_q == CMD_PRESET));
      do_snap    = (state == S_EXEC) && (cmd_q == CMD_SNAPSHOT);
      step_inc   = pulse_inc | ((state == S_ACK) & pend_inc);
      step_dec   = pulse_dec | ((state == S_ACK) & pend_dec);
      next_count = count_value;
      ovf_hit    = 1'b0;
      unf_hit    = 1'b0;
      // Simultaneous inc and dec cancel: neither branch is taken.
      if (step_inc && !step_dec) begin
         if (count_value == MAX_VAL) begin
            ovf_hit    = 1'b1;
            next_count = SATURATE ? MAX_VAL : MIN_VAL;
         end else begin
            next_count = count_value + ONE;
         end
      end else if (step_dec && !step_inc) begin
         if (count_value == MIN_VAL) begin
            unf_hit    = 1'b1;
            next_count = SATURATE ? MIN_VAL : MAX_VAL;
         end else begin
            next_count = count_value - ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= S_IDLE;
         cmd_q          <= 2'b00;
         data_q         <= '0;
         pend_inc       <= 1'b0;
         pend_dec       <= 1'b0;
         count_value    <= '0;
         snapshot       <= '0;
         snapshot_valid <= 1'b0;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_bus.cmd_valid) begin
                  cmd_q  <= cmd_bus.cmd;
                  data_q <= cmd_bus.cmd_data;
                  state  <= S_EXEC;
               end
            end
            S_EXEC:  state <= S_ACK;
            default: state <= S_IDLE;
         endcase

         // A load wins over a same-cycle pulse; the pulse is replayed in S_ACK.
         if (do_load) begin
            pend_inc    <= pulse_inc;
            pend_dec    <= pulse_dec;
            count_value <= do_clear ? '0 : data_q;
         end else begin
            count_value <= next_count;
            if (state == S_ACK) begin
               pend_inc <= 1'b0;
               pend_dec <= 1'b0;
            end
         end

         if (do_clear) begin
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            snapshot_valid <= 1'b0;
         end else begin
            overflow  <= overflow  | (ovf_hit & ~do_load);
            underflow <= underflow | (unf_hit & ~do_load);
         end

         if (do_snap) begin
            snapshot       <= count_value;
            snapshot_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_count_ctrl.sv
// Bench for count_ctrl: wrap and saturate variants driven in lockstep and compared
// every cycle against an integer-arithmetic model, plus directed scenarios.
module tb_count_ctrl;

   localparam int     W    = 32;
   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   localparam logic [1:0] C_NOP    = 2'b00;
   localparam logic [1:0] C_CLEAR  = 2'b01;
   localparam logic [1:0] C_PRESET = 2'b10;
   localparam logic [1:0] C_SNAP   = 2'b11;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic inc_counter = 1'b0;
   logic dec_counter = 1'b0;
   logic enable = 1'b0;

   count_ctrl_if #(.COUNT_WIDTH(W)) bus0 ();
   count_ctrl_if #(.COUNT_WIDTH(W)) bus1 ();

   logic [W-1:0] cv0, cv1, sn0, sn1;
   logic         sv0, sv1, of0, of1, uf0, uf1;

   count_ctrl #(.COUNT_WIDTH(W), .SATURATE(1'b0)) dut0 (
      .clk            (clk),
      .reset          (reset),
      .inc_counter    (inc_counter),
      .dec_counter    (dec_counter),
      .enable         (enable),
      .cmd_bus        (bus0),
      .count_value    (cv0),
      .snapshot       (sn0),
      .snapshot_valid (sv0),
      .overflow       (of0),
      .underflow      (uf0)
   );

   count_ctrl #(.COUNT_WIDTH(W), .SATURATE(1'b1)) dut1 (
      .clk            (clk),
      .reset          (reset),
      .inc_counter    (inc_counter),
      .dec_counter    (dec_counter),
      .enable         (enable),
      .cmd_bus        (bus1),
      .count_value    (cv1),
      .snapshot       (sn1),
      .snapshot_valid (sv1),
      .overflow       (of1),
      .underflow      (uf1)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: positions as plain integers, command progress as cycles since acceptance.
   int         phase;
   logic [1:0] m_cmd;
   longint     m_data;
   int         pend;
   longint     m_pos [2];
   longint     m_snap [2];
   bit         m_ovf [2];
   bit         m_unf [2];
   bit         m_sv [2];

   task automatic check_val(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic void model_reset();
      phase = 0;
      m_cmd = C_NOP;
      m_data = 0;
      pend = 0;
      for (int s = 0; s < 2; s++) begin
         m_pos[s] = 0;
         m_snap[s] = 0;
         m_ovf[s] = 1'b0;
         m_unf[s] = 1'b0;
         m_sv[s] = 1'b0;
      end
   endfunction

   function automatic void apply_delta(input int s, input int delta);
      if (delta > 0) begin
         if (m_pos[s] == MAXV) begin
            m_ovf[s] = 1'b1;
            m_pos[s] = (s == 1) ? MAXV : MINV;
         end else m_pos[s] = m_pos[s] + 1;
      end else if (delta < 0) begin
         if (m_pos[s] == MINV) begin
            m_unf[s] = 1'b1;
            m_pos[s] = (s == 1) ? MINV : MAXV;
         end else m_pos[s] = m_pos[s] - 1;
      end
   endfunction

   function automatic void model_edge();
      int p;
      p = enable ? (int'(inc_counter) - int'(dec_counter)) : 0;
      if (!reset) begin
         model_reset();
         return;
      end
      if (phase == 0) begin
         for (int s = 0; s < 2; s++) apply_delta(s, p);
         if (bus0.cmd_valid) begin
            m_cmd  = bus0.cmd;
            m_data = longint'($signed(bus0.cmd_data));
            phase  = 1;
         end
      end else if (phase == 1) begin
         if (m_cmd == C_CLEAR || m_cmd == C_PRESET) begin
            pend = p;
            for (int s = 0; s < 2; s++) begin
               m_pos[s] = (m_cmd == C_CLEAR) ? 0 : m_data;
               if (m_cmd == C_CLEAR) begin
                  m_ovf[s] = 1'b0;
                  m_unf[s] = 1'b0;
                  m_sv[s]  = 1'b0;
               end
            end
         end else begin
            for (int s = 0; s < 2; s++) begin
               if (m_cmd == C_SNAP) begin
                  m_snap[s] = m_pos[s];
                  m_sv[s]   = 1'b1;
               end
               apply_delta(s, p);
            end
         end
         phase = 2;
      end else begin
         for (int s = 0; s < 2; s++) apply_delta(s, p + pend);
         pend  = 0;
         phase = 0;
      end
   endfunction

   task automatic check_all();
      check_val("cnt0", longint'($signed(cv0)), m_pos[0]);
      check_val("cnt1", longint'($signed(cv1)), m_pos[1]);
      check_val("snap0", longint'($signed(sn0)), m_snap[0]);
      check_val("snap1", longint'($signed(sn1)), m_snap[1]);
      check_val("snapv0", longint'(sv0), longint'(m_sv[0]));
      check_val("snapv1", longint'(sv1), longint'(m_sv[1]));
      check_val("ovf0", longint'(of0), longint'(m_ovf[0]));
      check_val("ovf1", longint'(of1), longint'(m_ovf[1]));
      check_val("unf0", longint'(uf0), longint'(m_unf[0]));
      check_val("unf1", longint'(uf1), longint'(m_unf[1]));
      check_val("ready0", longint'(bus0.cmd_ready), longint'(phase == 0));
      check_val("ready1", longint'(bus1.cmd_ready), longint'(phase == 0));
      check_val("done0", longint'(bus0.cmd_done), longint'(phase == 2));
      check_val("done1", longint'(bus1.cmd_done), longint'(phase == 2));
   endtask

   task automatic drive_cmd(input logic v, input logic [1:0] c, input logic [W-1:0] d);
      bus0.cmd_valid = v;
      bus0.cmd       = c;
      bus0.cmd_data  = d;
      bus1.cmd_valid = v;
      bus1.cmd       = c;
      bus1.cmd_data  = d;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic pulse(input logic pi, input logic pd);
      inc_counter = pi;
      dec_counter = pd;
      tick();
      inc_counter = 1'b0;
      dec_counter = 1'b0;
      idle(3);
   endtask

   // Returns at the negedge inside the S_ACK cycle; pi/pd land in the S_EXEC cycle.
   task automatic send(input logic [1:0] c, input logic [W-1:0] d, input logic pi, input logic pd);
      drive_cmd(1'b1, c, d);
      tick();
      drive_cmd(1'b0, C_NOP, '0);
      inc_counter = pi;
      dec_counter = pd;
      tick();
      inc_counter = 1'b0;
      dec_counter = 1'b0;
   endtask

   initial begin
      int last_pulse;
      logic [W-1:0] d;
      drive_cmd(1'b0, C_NOP, '0);
      model_reset();
      idle(2);
      check_val("rst_cnt", longint'($signed(cv0)), 0);
      check_val("rst_ready", longint'(bus0.cmd_ready), 1);
      check_val("rst_snapv", longint'(sv1), 0);
      reset = 1'b1;
      enable = 1'b1;
      idle(1);

      for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
      for (int i = 0; i < 2; i++) pulse(1'b0, 1'b1);
      check_val("t1_cnt", longint'($signed(cv0)), 3);
      check_val("t1_ovf", longint'(of0), 0);
      check_val("t1_unf", longint'(uf0), 0);

      send(C_PRESET, 32'h7FFF_FFFE, 1'b0, 1'b0);
      idle(2);
      pulse(1'b1, 1'b0);
      pulse(1'b1, 1'b0);
      check_val("t2_wrap", longint'($signed(cv0)), MINV);
      check_val("t2_sat", longint'($signed(cv1)), MAXV);
      check_val("t2_ovf0", longint'(of0), 1);
      check_val("t2_ovf1", longint'(of1), 1);

      send(C_PRESET, 32'd100, 1'b1, 1'b0);
      check_val("t3_done", longint'(bus0.cmd_done), 1);
      check_val("t3_load", longint'($signed(cv0)), 100);
      tick();
      check_val("t3_cnt", longint'($signed(cv0)), 101);
      idle(3);

      send(C_PRESET, 32'd42, 1'b0, 1'b0);
      idle(2);
      send(C_SNAP, '0, 1'b0, 1'b1);
      check_val("t4_snap", longint'($signed(sn0)), 42);
      check_val("t4_cnt", longint'($signed(cv0)), 41);
      check_val("t4_snapv", longint'(sv0), 1);
      idle(3);

      send(C_PRESET, 32'h8000_0000, 1'b0, 1'b0);
      idle(2);
      pulse(1'b0, 1'b1);
      check_val("t5_unf0", longint'(uf0), 1);
      check_val("t5_wrap", longint'($signed(cv0)), MAXV);
      check_val("t5_sat", longint'($signed(cv1)), MINV);
      send(C_CLEAR, '0, 1'b0, 1'b0);
      check_val("t5_cnt", longint'($signed(cv0)), 0);
      check_val("t5_ovf", longint'(of0), 0);
      check_val("t5_unf", longint'(uf0), 0);
      check_val("t5_snapv", longint'(sv0), 0);
      idle(2);
      enable = 1'b0;
      for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0);
      check_val("t5_dis", longint'($signed(cv0)), 0);
      enable = 1'b1;

      send(C_PRESET, 32'd7, 1'b0, 1'b0);
      idle(2);
      drive_cmd(1'b1, C_PRESET, 32'd500);
      tick();
      drive_cmd(1'b0, C_NOP, '0);
      reset = 1'b0;
      model_reset();
      #1;
      check_val("t6_cnt", longint'($signed(cv0)), 0);
      check_val("t6_ready", longint'(bus0.cmd_ready), 1);
      check_val("t6_done", longint'(bus0.cmd_done), 0);
      @(negedge clk);
      check_all();
      tick();
      reset = 1'b1;
      idle(3);
      send(C_PRESET, 32'd7, 1'b0, 1'b0);
      idle(2);
      pulse(1'b1, 1'b1);
      check_val("t6_both", longint'($signed(cv0)), 7);
      check_val("t6_noflag", longint'(of0), 0);

      last_pulse = -10;
      for (int n = 0; n < 3000; n++) begin
         enable = ($urandom_range(0, 9) != 0);
         inc_counter = 1'b0;
         dec_counter = 1'b0;
         if ((n - last_pulse) >= 3 && $urandom_range(0, 2) == 0) begin
            last_pulse = n;
            case ($urandom_range(0, 3))
               0: inc_counter = 1'b1;
               1: dec_counter = 1'b1;
               2: begin inc_counter = 1'b1; dec_counter = 1'b1; end
               default: inc_counter = 1'b1;
            endcase
         end
         case ($urandom_range(0, 4))
            0: d = 32'h7FFF_FFFF;
            1: d = 32'h7FFF_FFFE;
            2: d = 32'h8000_0000;
            3: d = 32'h8000_0001;
            default: d = $urandom;
         endcase
         drive_cmd(($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)), d);
         if ($urandom_range(0, 499) == 0) begin
            reset = 1'b0;
            model_reset();
            tick();
            reset = 1'b1;
         end else begin
            tick();
         end
      end
      drive_cmd(1'b0, C_NOP, '0);
      inc_counter = 1'b0;
      dec_counter = 1'b0;
      idle(4);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
